// File: rtl/rv_rr_arb_if.sv
// Valid/ready bundle between four requesters and one shared output stream.
// The arbiter connects through the slave modport; the environment uses master.
interface rv_rr_arb_if #(
    parameter int unsigned wd = 4,
    parameter int unsigned N  = 4
);
    logic [N*wd-1:0] datain;
    logic [N-1:0]    datain_last;
    logic [N-1:0]    datain_val;
    logic [N-1:0]    datain_rdy;
    logic [wd-1:0]   dataout;
    logic            dataout_last;
    logic [1:0]      dataout_src;
    logic            dataout_val;
    logic            dataout_rdy;

    modport master (
        output datain, datain_last, datain_val, dataout_rdy,
        input  datain_rdy, dataout, dataout_last, dataout_src, dataout_val
    );

    modport slave (
        input  datain, datain_last, datain_val, dataout_rdy,
        output datain_rdy, dataout, dataout_last, dataout_src, dataout_val
    );
endinterface

// File: rtl/rv_rr_arb.sv
// Four-way packet-aware round-robin arbiter with a registered main+skid output.
// Upstream ready depends only on datain_val and registered state.
module rv_rr_arb #(
    parameter int unsigned wd = 4,
    parameter int unsigned N  = 4
) (
    input logic         clk,
    input logic         rst,
    rv_rr_arb_if.slave  bus
);
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [1:0]      ptr;
    logic [1:0]      lock_src;
    logic [1:0]      gnt;
    logic            gnt_vld;
    logic            acc;
    logic            acc_last;
    logic [wd-1:0]   acc_data;
    logic            out_xfer;

    logic [wd-1:0]   main_data;
    logic            main_last;
    logic [1:0]      main_src;
    logic            main_val;
    logic [wd-1:0]   skid_data;
    logic            skid_last;
    logic [1:0]      skid_src;
    logic            skid_val;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM next state: a non-last beat locks, a last beat releases
    always_comb begin
        state_nxt = state;
        if (acc) state_nxt = acc_last ? IDLE : LOCKED;
    end

    // FSM outputs: grant and per-requester ready
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        if (state == LOCKED) begin
            gnt     = lock_src;
            gnt_vld = 1'b1;
        end else begin
            // walk backwards so the requester closest to ptr wins
            for (int k = 3; k >= 0; k--) begin
                if (bus.datain_val[ptr + 2'(k)]) begin
                    gnt     = ptr + 2'(k);
                    gnt_vld = 1'b1;
                end
            end
        end
        bus.datain_rdy = '0;
        if (gnt_vld && !skid_val) bus.datain_rdy[gnt] = 1'b1;
    end

    always_comb begin
        acc_data = '0;
        acc_last = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (gnt == 2'(i)) begin
                acc_data = bus.datain[i*wd +: wd];
                acc_last = bus.datain_last[i];
            end
        end
    end

    assign acc      = |(bus.datain_val & bus.datain_rdy);
    assign out_xfer = main_val && bus.dataout_rdy;

    // round-robin pointer and packet owner
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            lock_src <= '0;
        end else if (acc) begin
            if (acc_last) ptr      <= gnt + 2'd1;
            else          lock_src <= gnt;
        end
    end

    // main/skid output stage; accept is impossible while skid is full
    always_ff @(posedge clk) begin
        if (rst) begin
            main_data <= '0;
            main_last <= 1'b0;
            main_src  <= '0;
            main_val  <= 1'b0;
            skid_data <= '0;
            skid_last <= 1'b0;
            skid_src  <= '0;
            skid_val  <= 1'b0;
        end else if (acc) begin
            if (!main_val || out_xfer) begin
                main_data <= acc_data;
                main_last <= acc_last;
                main_src  <= gnt;
                main_val  <= 1'b1;
            end else begin
                skid_data <= acc_data;
                skid_last <= acc_last;
                skid_src  <= gnt;
                skid_val  <= 1'b1;
            end
        end else if (out_xfer) begin
            if (skid_val) begin
                main_data <= skid_data;
                main_last <= skid_last;
                main_src  <= skid_src;
                skid_val  <= 1'b0;
            end else begin
                main_val  <= 1'b0;
            end
        end
    end

    assign bus.dataout      = main_data;
    assign bus.dataout_last = main_last;
    assign bus.dataout_src  = main_src;
    assign bus.dataout_val  = main_val;
endmodule

// File: tb/tb_rv_rr_arb.sv
// Directed bench for rv_rr_arb: vector table plus hand-written multi-cycle sequences.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_rv_rr_arb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rv_rr_arb_if #(.wd(4), .N(4)) bus ();
    rv_rr_arb #(.wd(4), .N(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic        r;
        logic [3:0]  val;
        logic [3:0]  last;
        logic [15:0] din;
        logic        drdy;
        logic        chk;
        logic        full;
        logic [3:0]  e_rdy;
        logic        e_val;
        logic [1:0]  e_src;
        logic [3:0]  e_data;
        logic        e_last;
    } vec_t;

    localparam logic [15:0] D = 16'h4321;

    int    n_vec  = 0;
    int    n_err  = 0;
    int    step   = 0;
    string phase  = "init";

    function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [3:0] l,
                                input logic [15:0] d, input logic dr, input logic c,
                                input logic f, input logic [3:0] er, input logic ev,
                                input logic [1:0] es, input logic [3:0] ed, input logic el);
        vec_t t;
        t.r = r; t.val = v; t.last = l; t.din = d; t.drdy = dr; t.chk = c; t.full = f;
        t.e_rdy = er; t.e_val = ev; t.e_src = es; t.e_data = ed; t.e_last = el;
        return t;
    endfunction

    function automatic vec_t rst_vec();
        return mk(1'b1, 4'b0, 4'b0, 16'h0, 1'b1, 1'b0, 1'b0, 4'b0, 1'b0, 2'd0, 4'h0, 1'b0);
    endfunction

    task automatic cmp(input string what, input logic [3:0] got, input logic [3:0] exp);
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s step %0d %s: got %h want %h", phase, step, what, got, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        rst             = v.r;
        bus.datain_val  = v.val;
        bus.datain_last = v.last;
        bus.datain      = v.din;
        bus.dataout_rdy = v.drdy;
        #1;
        step++;
        if (v.chk) begin
            n_vec++;
            cmp("datain_rdy", bus.datain_rdy, v.e_rdy);
            cmp("dataout_val", 4'(bus.dataout_val), 4'(v.e_val));
            if (v.e_val || v.full) begin
                cmp("dataout_src", 4'(bus.dataout_src), 4'(v.e_src));
                cmp("dataout", bus.dataout, v.e_data);
                cmp("dataout_last", 4'(bus.dataout_last), 4'(v.e_last));
            end
        end
    endtask

    task automatic begin_phase(input string name);
        phase = name;
        step  = 0;
        apply(rst_vec());
    endtask

    vec_t tbl[$];

    initial begin
        bus.datain      = '0;
        bus.datain_last = '0;
        bus.datain_val  = '0;
        bus.dataout_rdy = 1'b0;

        // fairness: four single-beat requesters, payloads 1..4
        tbl.push_back(rst_vec());
        tbl.push_back(mk(0, 4'hF, 4'hF, D, 1, 1, 1, 4'b0001, 0, 2'd0, 4'h0, 0));
        tbl.push_back(mk(0, 4'hF, 4'hF, D, 1, 1, 0, 4'b0010, 1, 2'd0, 4'h1, 1));
        tbl.push_back(mk(0, 4'hF, 4'hF, D, 1, 1, 0, 4'b0100, 1, 2'd1, 4'h2, 1));
        tbl.push_back(mk(0, 4'hF, 4'hF, D, 1, 1, 0, 4'b1000, 1, 2'd2, 4'h3, 1));
        tbl.push_back(mk(0, 4'hF, 4'hF, D, 1, 1, 0, 4'b0001, 1, 2'd3, 4'h4, 1));
        tbl.push_back(mk(0, 4'hF, 4'hF, D, 1, 1, 0, 4'b0010, 1, 2'd0, 4'h1, 1));
        // packet lock: src0 single beat, then src1 three beats, src2 waits
        tbl.push_back(rst_vec());
        tbl.push_back(mk(0, 4'b0111, 4'b0101, D, 1, 1, 0, 4'b0001, 0, 2'd0, 4'h0, 0));
        tbl.push_back(mk(0, 4'b0111, 4'b0101, D, 1, 1, 0, 4'b0010, 1, 2'd0, 4'h1, 1));
        tbl.push_back(mk(0, 4'b0111, 4'b0101, D, 1, 1, 0, 4'b0010, 1, 2'd1, 4'h2, 0));
        tbl.push_back(mk(0, 4'b0111, 4'b0111, D, 1, 1, 0, 4'b0010, 1, 2'd1, 4'h2, 0));
        tbl.push_back(mk(0, 4'b0101, 4'b0101, D, 1, 1, 0, 4'b0100, 1, 2'd1, 4'h2, 1));
        tbl.push_back(mk(0, 4'b0001, 4'b0101, D, 1, 1, 0, 4'b0001, 1, 2'd2, 4'h3, 1));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, D, 1, 1, 0, 4'b0000, 1, 2'd0, 4'h1, 1));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, D, 1, 1, 0, 4'b0000, 0, 2'd0, 4'h0, 0));
        // hole: only src3 valid, pointer must wrap to 0 afterwards
        tbl.push_back(rst_vec());
        tbl.push_back(mk(0, 4'b1000, 4'b1000, D, 1, 1, 1, 4'b1000, 0, 2'd0, 4'h0, 0));
        tbl.push_back(mk(0, 4'b1010, 4'b1010, D, 1, 1, 0, 4'b0010, 1, 2'd3, 4'h4, 1));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, D, 1, 1, 0, 4'b0000, 1, 2'd1, 4'h2, 1));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, D, 1, 1, 0, 4'b0000, 0, 2'd0, 4'h0, 0));

        phase = "table";
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // backpressure: main and skid fill, ready drops, order 1,2,3,4 kept
        begin_phase("skid");
        apply(mk(0, 4'b0001, 4'b0001, 16'h0001, 0, 1, 0, 4'b0001, 0, 2'd0, 4'h0, 0));
        apply(mk(0, 4'b0001, 4'b0001, 16'h0002, 0, 1, 0, 4'b0001, 1, 2'd0, 4'h1, 1));
        apply(mk(0, 4'b0001, 4'b0001, 16'h0003, 0, 1, 0, 4'b0000, 1, 2'd0, 4'h1, 1));
        apply(mk(0, 4'b0001, 4'b0001, 16'h0003, 1, 1, 0, 4'b0000, 1, 2'd0, 4'h1, 1));
        apply(mk(0, 4'b0001, 4'b0001, 16'h0003, 1, 1, 0, 4'b0001, 1, 2'd0, 4'h2, 1));
        apply(mk(0, 4'b0001, 4'b0001, 16'h0004, 1, 1, 0, 4'b0001, 1, 2'd0, 4'h3, 1));
        apply(mk(0, 4'b0000, 4'b0000, 16'h0004, 1, 1, 0, 4'b0000, 1, 2'd0, 4'h4, 1));
        apply(mk(0, 4'b0000, 4'b0000, 16'h0004, 1, 1, 0, 4'b0000, 0, 2'd0, 4'h0, 0));

        // stalled lock: src2 pauses mid-packet, src0 must not be served
        begin_phase("stall");
        apply(mk(0, 4'b0100, 4'b0000, 16'h0509, 1, 1, 0, 4'b0100, 0, 2'd0, 4'h0, 0));
        apply(mk(0, 4'b0001, 4'b0001, 16'h0509, 1, 1, 0, 4'b0100, 1, 2'd2, 4'h5, 0));
        for (int i = 0; i < 3; i++)
            apply(mk(0, 4'b0001, 4'b0001, 16'h0509, 1, 1, 0, 4'b0100, 0, 2'd0, 4'h0, 0));
        apply(mk(0, 4'b0101, 4'b0101, 16'h0609, 1, 1, 0, 4'b0100, 0, 2'd0, 4'h0, 0));
        apply(mk(0, 4'b0001, 4'b0001, 16'h0609, 1, 1, 0, 4'b0001, 1, 2'd2, 4'h6, 1));
        apply(mk(0, 4'b0000, 4'b0000, 16'h0609, 1, 1, 0, 4'b0000, 1, 2'd0, 4'h9, 1));
        apply(mk(0, 4'b0000, 4'b0000, 16'h0609, 1, 1, 0, 4'b0000, 0, 2'd0, 4'h0, 0));

        // reset while locked on src1 with the skid full
        begin_phase("midrst");
        apply(mk(0, 4'b0010, 4'b0000, 16'h0079, 0, 1, 0, 4'b0010, 0, 2'd0, 4'h0, 0));
        apply(mk(0, 4'b0011, 4'b0001, 16'h0089, 0, 1, 0, 4'b0010, 1, 2'd1, 4'h7, 0));
        apply(mk(1, 4'b0011, 4'b0001, 16'h0089, 0, 1, 0, 4'b0000, 1, 2'd1, 4'h7, 0));
        apply(mk(0, 4'b0011, 4'b0001, 16'h0089, 1, 1, 1, 4'b0001, 0, 2'd0, 4'h0, 0));
        apply(mk(0, 4'b0000, 4'b0000, 16'h0089, 1, 1, 0, 4'b0000, 1, 2'd0, 4'h9, 1));
        apply(mk(0, 4'b0000, 4'b0000, 16'h0089, 1, 1, 0, 4'b0000, 0, 2'd0, 4'h0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
